squarewave_sequencer: RTL and testbench
=======================================

Name: squarewave_sequencer

Overview:
Sequences a square-wave output through a small programmable table of segments. Each segment is (m, n, rep): high for m*TICK_DIV clocks, low for n*TICK_DIV clocks, repeated rep times. It sits between the control/config logic and the wave output pin. It generalises the fixed m/n generator with start/stop control, a playlist and glitch-free segment changes.

Parameters:
TICK_DIV, 5, clocks per m/n unit (20 ns clk gives 100 ns per unit)
DEPTH, 4, number of table entries (power of 2)
REP_W, 8, width of repeat count

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  log2(DEPTH)  table entry to write
cfg_m  in  4  high units
cfg_n  in  4  low units
cfg_rep  in  REP_W  periods per segment
cfg_err  out  1  one-cycle pulse: write rejected
seg_last  in  log2(DEPTH)  index of last segment, sampled on accepted start
loop  in  1  wrap to entry 0 after seg_last, sampled on accepted start
start  in  1  begin playback from entry 0 (level sampled each clk)
stop  in  1  abort playback
busy  out  1  high while playing
seg_idx  out  log2(DEPTH)  entry currently playing
done  out  1  one-cycle pulse when a non-looping run completes
w  out  1  square-wave output, registered

Behaviour:
- Reset (async, rst_n=0): state IDLE, w=0, busy=0, done=0, cfg_err=0, seg_idx=0, counters=0. Every table entry resets to m=1, n=1, rep=1.
- Table write: on cfg_we, if cfg_m, cfg_n and cfg_rep are all nonzero, store them at cfg_addr. Otherwise ignore the write and pulse cfg_err the next cycle. Zero-length phases are therefore impossible.
- Writes are legal while busy. An entry's fields are latched into working registers when that segment is loaded. A write to the playing entry takes effect at its next load.
- States are IDLE, HIGH and LOW.
- IDLE: w=0.
  - start=1 and stop=0 at edge T: load entry 0 and latch seg_last/loop.
  - From T+1: state HIGH, w=1, busy=1, seg_idx=0.
- Phase counter is loaded with m*TICK_DIV-1 (or n*TICK_DIV-1) and decrements to 0. Width is 4+clog2(TICK_DIV+1) bits, sized so the max product 15*TICK_DIV never overflows.
- HIGH: w stays 1 for exactly m*TICK_DIV cycles, then LOW with w=0.
- LOW: w stays 0 for exactly n*TICK_DIV cycles, then:
  - rep count not yet reached: back to HIGH with the same entry.
  - rep reached and seg_idx<seg_last: load the next entry, go to HIGH, seg_idx increments on the same edge. There is no gap cycle between segments.
  - rep reached, seg_idx==seg_last, loop=1: load entry 0, go to HIGH.
  - rep reached, seg_idx==seg_last, loop=0: go to IDLE, busy=0, done=1 for that one cycle, w=0.
- The output period is always exactly (m+n)*TICK_DIV clocks with no glitches or extra cycles at segment boundaries.
- stop=1 in any non-IDLE state: next cycle IDLE, w=0, busy=0, done not pulsed, seg_idx=0.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- seg_last is not checked against table contents; any index is legal.
- Asserting rst_n mid-run returns everything to the reset values immediately. Table contents are lost.

Decomposition:
- Package squarewave_pkg holds:
  - state enum {IDLE, HIGH, LOW}
  - constants MN_W=4, DEPTH, TICK_DIV
  - segment struct {m, n, rep}
- Sub-module sqw_phase_timer: a loadable down-counter with load value and terminal-count flag, instantiated once.
- Table storage is a register array inside the top module; no RAM inference.

Test Plan:
- Reset, then write entry0 (m=2, n=1, rep=2), seg_last=0, loop=0, start at cycle 0 -> w high cycles 1-10, low 11-15, high 16-25, low 26-30. done pulses at cycle 31, busy falls at 31, w=0.
- Write entry0 (1,1,1) and entry1 (3,2,1), seg_last=1 -> w high 5, low 5, high 15, low 10. seg_idx changes 0->1 on the same edge w rises for entry1. No gap cycle.
- Same table with loop=1, run 3 full passes, then pulse stop mid-HIGH -> w=0 and busy=0 the next cycle. done never asserts.
- Write with cfg_n=0 -> cfg_err pulses one cycle and the entry keeps its prior value. Play it and verify the prior timing.
- While entry1 plays, rewrite entry1 to (2,2,1) -> the current pass keeps the old timing. The next loop pass uses the new 10/10 timing.
- Drive start and stop together in IDLE -> stays IDLE. Assert rst_n=0 mid-LOW -> w=0, busy=0 with no clock needed, and the table reads back the reset default (1,1,1).

Source files
------------

// File: rtl/squarewave_pkg.sv
// Shared types and constants for the square-wave sequencer.
// Segment table entries and playback state live here.
package squarewave_pkg;

  localparam int MN_W     = 4;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 5;
  localparam int REP_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MN_W-1:0]  m;
    logic [MN_W-1:0]  n;
    logic [REP_W-1:0] rep;
  } segment_t;

  localparam segment_t SEG_RST = '{
    m:   MN_W'(1),
    n:   MN_W'(1),
    rep: REP_W'(1)
  };

endpackage

// File: rtl/sqw_phase_timer.sv
// Loadable down-counter timing one high or low phase.
// tc flags the last cycle of the phase.
module sqw_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/squarewave_sequencer.sv
// Plays a programmable list of (m, n, rep) square-wave segments.
// Segment changes land on a period boundary with no gap cycle.
module squarewave_sequencer #(
  parameter int TICK_DIV = squarewave_pkg::TICK_DIV,
  parameter int DEPTH    = squarewave_pkg::DEPTH,
  parameter int REP_W    = squarewave_pkg::REP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [3:0]               cfg_m,
  input  logic [3:0]               cfg_n,
  input  logic [REP_W-1:0]         cfg_rep,
  output logic                     cfg_err,
  input  logic [$clog2(DEPTH)-1:0] seg_last,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] seg_idx,
  output logic                     done,
  output logic                     w
);

  import squarewave_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int PH_W = MN_W + $clog2(TICK_DIV + 1);

  function automatic logic [PH_W-1:0] units(
    input logic [MN_W-1:0] u
  );
    return PH_W'(u) * PH_W'(TICK_DIV) - PH_W'(1);
  endfunction

  segment_t          tbl [DEPTH];
  segment_t          cur;
  segment_t          nxt_seg;
  state_t            state, state_n;
  logic [REP_W-1:0]  rep_left;
  logic [AW-1:0]     last_q;
  logic              loop_q;
  logic [AW-1:0]     nxt_idx;
  logic              seg_ld;
  logic              rep_dec;
  logic              ld;
  logic [PH_W-1:0]   ld_val;
  logic              tc;
  logic              w_n, busy_n, done_n;
  logic              cfg_ok;
  logic              go;
  logic              more, adv, wrap, fin;

  assign cfg_ok  = (cfg_m != '0) && (cfg_n != '0)
                && (cfg_rep != '0);
  assign go      = (state == IDLE) && start && !stop;
  assign nxt_seg = tbl[nxt_idx];

  assign more = (rep_left > REP_W'(1));
  assign adv  = !more && (seg_idx != last_q);
  assign wrap = !more && (seg_idx == last_q) && loop_q;
  assign fin  = !more && (seg_idx == last_q) && !loop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= SEG_RST;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        tbl[cfg_addr] <= '{m: cfg_m, n: cfg_n, rep: cfg_rep};
      end
    end
  end

  sqw_phase_timer #(.W(PH_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    seg_ld  = 1'b0;
    nxt_idx = seg_idx;
    rep_dec = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n = HIGH;
          seg_ld  = 1'b1;
          nxt_idx = '0;
          ld      = 1'b1;
          ld_val  = units(nxt_seg.m);
        end
      end
      HIGH: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tc) begin
          state_n = LOW;
          ld      = 1'b1;
          ld_val  = units(cur.n);
        end
      end
      LOW: begin
        if (stop) begin
          state_n = IDLE;
        end else if (tc) begin
          unique case (1'b1)
            more: begin
              state_n = HIGH;
              rep_dec = 1'b1;
              ld      = 1'b1;
              ld_val  = units(cur.m);
            end
            adv, wrap: begin
              state_n = HIGH;
              seg_ld  = 1'b1;
              nxt_idx = adv ? seg_idx + AW'(1) : '0;
              ld      = 1'b1;
              ld_val  = units(nxt_seg.m);
            end
            fin: state_n = IDLE;
            default: state_n = IDLE;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) begin
      ld     = 1'b1;
      ld_val = '0;
    end
  end

  always_comb begin
    w_n    = (state_n == HIGH);
    busy_n = (state_n != IDLE);
    done_n = (state == LOW) && (state_n == IDLE) && !stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seg_idx  <= '0;
      cur      <= '0;
      rep_left <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
    end else begin
      w    <= w_n;
      busy <= busy_n;
      done <= done_n;
      if (go) begin
        last_q <= seg_last;
        loop_q <= loop;
      end
      if (state_n == IDLE) begin
        seg_idx  <= '0;
        rep_left <= '0;
      end else if (seg_ld) begin
        seg_idx  <= nxt_idx;
        cur      <= nxt_seg;
        rep_left <= nxt_seg.rep;
      end else if (rep_dec) begin
        rep_left <= rep_left - REP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_squarewave_sequencer.sv
// Directed bench for squarewave_sequencer: config vectors plus
// hand-timed playback sequences checked cycle by cycle.
module tb_squarewave_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_m, cfg_n;
  logic [7:0] cfg_rep;
  logic       cfg_err;
  logic [1:0] seg_last;
  logic       loop, start, stop;
  logic       busy, done, w;
  logic [1:0] seg_idx;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int snap;

  typedef struct {
    logic [1:0] a;
    logic [3:0] m;
    logic [3:0] n;
    logic [7:0] rep;
    logic       err;
  } cfg_vec_t;

  cfg_vec_t cv [6];

  squarewave_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_m    (cfg_m),
    .cfg_n    (cfg_n),
    .cfg_rep  (cfg_rep),
    .cfg_err  (cfg_err),
    .seg_last (seg_last),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .seg_idx  (seg_idx),
    .done     (done),
    .w        (w)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Check w/busy/seg_idx for cyc consecutive negedges.
  task automatic hold(input string nm, input logic lvl,
                      input int cyc, input logic [1:0] idx);
    int bad_at = -1;
    logic bw = 1'b0, bb = 1'b0;
    logic [1:0] bi = '0;
    for (int i = 0; i < cyc; i++) begin
      if (bad_at < 0 &&
          (w !== lvl || busy !== 1'b1 || seg_idx !== idx)) begin
        bad_at = i; bw = w; bb = busy; bi = seg_idx;
      end
      @(negedge clk);
    end
    total++;
    if (bad_at >= 0) begin
      bad++;
      $display("FAIL %s: cycle %0d w=%b busy=%b idx=%0d want w=%b busy=1 idx=%0d",
               nm, bad_at, bw, bb, bi, lvl, idx);
    end
  endtask

  task automatic apply_cfg(input int i);
    cfg_we   = 1'b1;
    cfg_addr = cv[i].a;
    cfg_m    = cv[i].m;
    cfg_n    = cv[i].n;
    cfg_rep  = cv[i].rep;
    @(negedge clk);
    cfg_we = 1'b0;
    chk($sformatf("cfg_err[%0d]", i), 32'(cfg_err),
        32'(cv[i].err));
    @(negedge clk);
    chk($sformatf("cfg_err_clr[%0d]", i), 32'(cfg_err), 0);
  endtask

  task automatic start_run(input logic [1:0] last,
                           input logic lp);
    seg_last = last;
    loop     = lp;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_done(input string nm);
    chk({nm, "_done"}, 32'(done), 1);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_w"}, 32'(w), 0);
    @(negedge clk);
    chk({nm, "_done_clr"}, 32'(done), 0);
  endtask

  task automatic do_stop(input string nm);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk({nm, "_w"}, 32'(w), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_idx"}, 32'(seg_idx), 0);
    chk({nm, "_done"}, 32'(done), 0);
  endtask

  initial begin
    cv[0] = '{a: 2'd0, m: 4'd2, n: 4'd1, rep: 8'd2, err: 1'b0};
    cv[1] = '{a: 2'd0, m: 4'd1, n: 4'd1, rep: 8'd1, err: 1'b0};
    cv[2] = '{a: 2'd1, m: 4'd3, n: 4'd2, rep: 8'd1, err: 1'b0};
    cv[3] = '{a: 2'd0, m: 4'd1, n: 4'd0, rep: 8'd1, err: 1'b1};
    cv[4] = '{a: 2'd0, m: 4'd0, n: 4'd3, rep: 8'd1, err: 1'b1};
    cv[5] = '{a: 2'd0, m: 4'd2, n: 4'd2, rep: 8'd0, err: 1'b1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_m = '0; cfg_n = '0; cfg_rep = '0;
    seg_last = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_w", 32'(w), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_idx", 32'(seg_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single segment (2,1,2), no loop
    apply_cfg(0);
    start_run(2'd0, 1'b0);
    hold("t1_h1", 1'b1, 10, 2'd0);
    hold("t1_l1", 1'b0, 5, 2'd0);
    hold("t1_h2", 1'b1, 10, 2'd0);
    hold("t1_l2", 1'b0, 5, 2'd0);
    chk_done("t1");

    // two segments, no gap at the boundary
    apply_cfg(1);
    apply_cfg(2);
    start_run(2'd1, 1'b0);
    hold("t2_h0", 1'b1, 5, 2'd0);
    hold("t2_l0", 1'b0, 5, 2'd0);
    hold("t2_h1", 1'b1, 15, 2'd1);
    hold("t2_l1", 1'b0, 10, 2'd1);
    chk_done("t2");

    // looping playlist, stop mid-HIGH
    snap = done_cnt;
    start_run(2'd1, 1'b1);
    for (int p = 0; p < 3; p++) begin
      hold($sformatf("t3_h0_p%0d", p), 1'b1, 5, 2'd0);
      hold($sformatf("t3_l0_p%0d", p), 1'b0, 5, 2'd0);
      hold($sformatf("t3_h1_p%0d", p), 1'b1, 15, 2'd1);
      hold($sformatf("t3_l1_p%0d", p), 1'b0, 10, 2'd1);
    end
    hold("t3_h0_p3", 1'b1, 2, 2'd0);
    do_stop("t3_stop");
    @(negedge clk);
    chk("t3_idle_busy", 32'(busy), 0);
    chk("t3_no_done", 32'(done_cnt - snap), 0);

    // rejected writes keep entry0 at (1,1,1)
    apply_cfg(3);
    apply_cfg(4);
    apply_cfg(5);
    start_run(2'd0, 1'b0);
    hold("t4_h", 1'b1, 5, 2'd0);
    hold("t4_l", 1'b0, 5, 2'd0);
    chk_done("t4");

    // rewrite the playing entry; takes effect next pass
    start_run(2'd1, 1'b1);
    hold("t5_h0", 1'b1, 5, 2'd0);
    hold("t5_l0", 1'b0, 5, 2'd0);
    hold("t5_h1a", 1'b1, 3, 2'd1);
    cfg_we = 1'b1; cfg_addr = 2'd1;
    cfg_m = 4'd2; cfg_n = 4'd2; cfg_rep = 8'd1;
    hold("t5_h1b", 1'b1, 1, 2'd1);
    cfg_we = 1'b0;
    chk("t5_err", 32'(cfg_err), 0);
    hold("t5_h1c", 1'b1, 11, 2'd1);
    hold("t5_l1", 1'b0, 10, 2'd1);
    hold("t5_h0b", 1'b1, 5, 2'd0);
    hold("t5_l0b", 1'b0, 5, 2'd0);
    hold("t5_h1n", 1'b1, 10, 2'd1);
    hold("t5_l1n", 1'b0, 10, 2'd1);
    hold("t5_h0c", 1'b1, 5, 2'd0);
    do_stop("t5_stop");

    // start+stop together in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t6_ss_busy", 32'(busy), 0);
    chk("t6_ss_w", 32'(w), 0);
    @(negedge clk);
    chk("t6_ss_busy2", 32'(busy), 0);

    // async reset mid-LOW, then table is back to defaults
    start_run(2'd0, 1'b0);
    hold("t6_h", 1'b1, 5, 2'd0);
    hold("t6_l", 1'b0, 2, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_w", 32'(w), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_idx", 32'(seg_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(2'd1, 1'b0);
    hold("t6_h0", 1'b1, 5, 2'd0);
    hold("t6_l0", 1'b0, 5, 2'd0);
    hold("t6_h1", 1'b1, 5, 2'd1);
    hold("t6_l1", 1'b0, 5, 2'd1);
    chk_done("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
